// File: rtl/psum_deskew_collector_pkg.sv
// rtl/psum_deskew_collector_pkg.sv - shared lane/vector types and signed saturating add
package psum_deskew_collector_pkg;

  localparam int LANES = 4;
  localparam int SUM_W = 16;

  typedef logic signed [SUM_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;

  localparam lane_t LANE_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam lane_t LANE_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // One extra bit of headroom; a sign mismatch between the top two bits means overflow
  function automatic lane_t sat_add(input lane_t a, input lane_t b);
    logic signed [SUM_W:0] s;
    s = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (s[SUM_W] != s[SUM_W-1]) return s[SUM_W] ? LANE_MIN : LANE_MAX;
    return s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/psum_vec_fifo.sv
// rtl/psum_vec_fifo.sv - synchronous vector FIFO with a registered head word
module psum_vec_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  head_q;
  logic          do_push, do_pop;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign do_pop     = pop && !empty;
  // A pop frees the slot this cycle, so a push at full still fits
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign rdata      = head_q;
  assign count      = cnt_q;

  // Storage array; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and the head register; head only moves on a pop or a push into empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      if (do_pop) begin
        if (cnt_q > CW'(1)) head_q <= mem[rd_ptr_nxt];
        else if (do_push)   head_q <= wdata;
      end else if (empty && do_push) begin
        head_q <= wdata;
      end
    end
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// rtl/psum_deskew_collector.sv - partial-sum de-skew, FIFO buffering and stall warning; PSUM_ACC_EN adds multi-pass accumulation
module psum_deskew_collector #(
  parameter int LANES        = psum_deskew_collector_pkg::LANES,
  parameter int SUM_W        = psum_deskew_collector_pkg::SUM_W,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 4
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    clr_i,
  input  logic                    sum_vld_i,
  input  logic signed [SUM_W-1:0] sum_1_i,
  input  logic signed [SUM_W-1:0] sum_2_i,
  input  logic signed [SUM_W-1:0] sum_3_i,
  input  logic signed [SUM_W-1:0] sum_4_i,
  input  logic [3:0]              acc_len_i,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i,
  output logic [LANES*SUM_W-1:0]  out_data_o,
  output logic                    stall_o,
  output logic                    ovf_o,
  output logic [$clog2(DEPTH):0]  cnt_o
);
  import psum_deskew_collector_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    vld_sr;
  lane_t [2:0]   l1_sr;
  lane_t [1:0]   l2_sr;
  lane_t         l3_sr;
  logic          aligned_vld;
  vec_t          aligned;
  logic          push_req;
  vec_t          push_data;
  logic          pop, fifo_full, fifo_empty, ovf_q;
  logic [CW-1:0] free_slots;

  // Delay lanes 1..3 and the lane-0 valid so every lane of one vector lines up with lane 4
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_sr <= '0;
      l1_sr  <= '0;
      l2_sr  <= '0;
      l3_sr  <= '0;
    end else if (clr_i) begin
      vld_sr <= '0;
      l1_sr  <= '0;
      l2_sr  <= '0;
      l3_sr  <= '0;
    end else begin
      vld_sr <= {vld_sr[1:0], sum_vld_i};
      l1_sr  <= {l1_sr[1:0], sum_1_i};
      l2_sr  <= {l2_sr[0], sum_2_i};
      l3_sr  <= sum_3_i;
    end
  end

  assign aligned_vld = vld_sr[2];
  assign aligned     = {sum_4_i, l3_sr, l2_sr[1], l1_sr[2]};

`ifdef PSUM_ACC_EN
  vec_t       acc_q, acc_nxt;
  logic [3:0] pass_cnt, len_q, eff_len;
  logic       last_pass;

  // Pass length is latched on the first pass; the first pass overwrites, later passes saturate-add
  always_comb begin
    eff_len = len_q;
    if (pass_cnt == 4'd0) eff_len = (acc_len_i == 4'd0) ? 4'd1 : acc_len_i;
    acc_nxt = aligned;
    for (int i = 0; i < LANES; i++) begin
      if (pass_cnt != 4'd0) acc_nxt[i] = sat_add(acc_q[i], aligned[i]);
    end
  end

  assign last_pass = (pass_cnt == eff_len - 4'd1);
  assign push_req  = aligned_vld && last_pass;
  assign push_data = acc_nxt;

  // Accumulator state; a dropped push still ends the group so the next one starts clean
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_q    <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
    end else if (clr_i) begin
      acc_q    <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
    end else if (aligned_vld) begin
      acc_q    <= acc_nxt;
      len_q    <= eff_len;
      pass_cnt <= last_pass ? 4'd0 : pass_cnt + 4'd1;
    end
  end
`else
  logic unused_acc_len;

  assign unused_acc_len = ^acc_len_i;
  assign push_req       = aligned_vld;
  assign push_data      = aligned;
`endif

  assign pop       = out_vld_o && out_rdy_i;
  assign out_vld_o = !fifo_empty;

  psum_vec_fifo #(
    .DEPTH (DEPTH),
    .W     (LANES*SUM_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (clr_i),
    .push  (push_req),
    .wdata (push_data),
    .pop   (pop),
    .rdata (out_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cnt_o)
  );

  // Sticky drop flag: a vector arrived at a full FIFO with nothing leaving
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                 ovf_q <= 1'b0;
    else if (clr_i)                            ovf_q <= 1'b0;
    else if (push_req && fifo_full && !pop)    ovf_q <= 1'b1;
  end

  assign ovf_o      = ovf_q;
  // Margin covers the three vectors already in the skew pipe plus the one being issued
  assign free_slots = CW'(DEPTH) - cnt_o;
  assign stall_o    = (free_slots <= CW'(STALL_MARGIN));

endmodule
